cga_bus_regs: RTL and testbench

//  Parametrised ISA-side front end for the CGA/Tandy video adapter.
//  - Decodes the adapter I/O window and holds mode, colour, Tandy border/mode-select and a palette of PAL_ENTRIES.
//  - Returns status and CRTC read data, and generates memory wait states aligned to the sequencer slot.
//  - Sits between the bus and the CRTC/sequencer/pixel pipeline; replaces the level-triggered register logic with edge-committed writes.

---
 rtl/cga_bus_pkg.sv | 23 ++
 rtl/cga_bus_regs_if.sv | 24 ++
 rtl/cga_wait_gen.sv | 100 ++++++++++
 rtl/cga_bus_regs.sv | 186 ++++++++++++++++++
 tb/tb_cga_bus_regs.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cga_bus_pkg.sv
// Shared constants and types for the CGA/Tandy bus register front end.
// Used by cga_bus_regs and cga_wait_gen (optional feature macro: CGA_BUS_WAIT_EN).
package cga_bus_pkg;

  // Register offsets within the 16-byte I/O window
  localparam logic [3:0] OFS_MODE  = 4'h8;
  localparam logic [3:0] OFS_COLOR = 4'h9;
  localparam logic [3:0] OFS_INDEX = 4'hA;
  localparam logic [3:0] OFS_DATA  = 4'hE;

  // Tandy indirect register indices
  localparam logic [7:0] IDX_BORDER  = 8'h02;
  localparam logic [7:0] IDX_MODESEL = 8'h03;

  // Memory wait-state sequencer states
  typedef enum logic [1:0] {
    WS_IDLE   = 2'd0,
    WS_SYNC   = 2'd1,
    WS_ACCESS = 2'd2,
    WS_DONE   = 2'd3
  } wait_state_t;

endpackage

// File: rtl/cga_bus_regs_if.sv
// ISA-side bus signals of the CGA adapter, grouped with master (bus host)
// and slave (adapter) views.
interface cga_bus_regs_if;
  logic [14:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_out;
  logic        bus_dir;
  logic        bus_rdy;

  modport master (
    output bus_a, bus_d, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen,
    input  bus_out, bus_dir, bus_rdy
  );

  modport slave (
    input  bus_a, bus_d, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen,
    output bus_out, bus_dir, bus_rdy
  );
endinterface

// File: rtl/cga_wait_gen.sv
// Memory wait-state generator: holds the ISA bus not-ready until the CPU
// access slot of the sequencer has passed, with a watchdog that releases the
// bus after WAIT_MAX cycles. Only built when CGA_BUS_WAIT_EN is defined.
module cga_wait_gen
  import cga_bus_pkg::*;
#(
  parameter logic [4:0] SLOT_START = 5'd17,
  parameter logic [4:0] SLOT_END   = 5'd20,
  parameter logic [7:0] WAIT_MAX   = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [4:0] clkdiv,
  output logic       bus_rdy
);

  wait_state_t state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wd_hit_s;

  // Watchdog fires on the last permitted wait cycle so bus_rdy is low WAIT_MAX cycles at most
  assign wd_hit_s = (cnt_q == (WAIT_MAX - 8'd1));
  assign bus_rdy  = rdy_q;

  // State, ready and watchdog registers; reset releases the bus immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WS_IDLE;
      rdy_q   <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, ready and watchdog counter decisions
  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    cnt_d   = cnt_q;
    case (state_q)
      WS_IDLE: begin
        if (req) begin
          state_d = WS_SYNC;
          rdy_d   = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          rdy_d   = 1'b1;
        end
      end
      WS_SYNC: begin
        if (!req) begin
          state_d = WS_IDLE;
          rdy_d   = 1'b1;
        end else if (wd_hit_s) begin
          state_d = WS_DONE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (clkdiv == SLOT_START) begin
            state_d = WS_ACCESS;
          end else begin
            state_d = WS_SYNC;
          end
        end
      end
      WS_ACCESS: begin
        if (!req) begin
          state_d = WS_IDLE;
          rdy_d   = 1'b1;
        end else if (clkdiv == SLOT_END) begin
          state_d = WS_DONE;
          rdy_d   = 1'b1;
        end else if (wd_hit_s) begin
          state_d = WS_DONE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WS_DONE: begin
        rdy_d = 1'b1;
        if (!req) begin
          state_d = WS_IDLE;
        end else begin
          state_d = WS_DONE;
        end
      end
      default: begin
        state_d = WS_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cga_bus_regs.sv
// ISA-side front end of the CGA/Tandy adapter: I/O window decode, mode/colour
// and Tandy indirect registers, palette, status/CRTC read-back and (with
// CGA_BUS_WAIT_EN defined) memory wait-state generation. Without the macro
// bus_rdy is tied high. Writes commit once on the synchronised iow_l edge.
module cga_bus_regs
  import cga_bus_pkg::*;
#(
  parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
  parameter int          PAL_ENTRIES  = 16,
  parameter int          PAL_W        = 4,
  parameter logic [7:0]  PAL_BASE     = 8'h10,
  parameter logic [4:0]  SLOT_START   = 5'd17,
  parameter logic [4:0]  SLOT_END     = 5'd20,
  parameter logic [7:0]  WAIT_MAX     = 8'd64,
  localparam int         PAL_AW       = $clog2(PAL_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  cga_bus_regs_if.slave     bus,
  input  logic              cga_hw,
  input  logic              mem_cs,
  input  logic [4:0]        clkdiv,
  input  logic              vsync_l,
  input  logic              display_enable,
  input  logic [7:0]        crtc_dout,
  output logic              crtc_cs,
  output logic [7:0]        mode_reg,
  output logic [7:0]        color_reg,
  output logic [3:0]        border_col,
  output logic [4:0]        modesel,
  input  logic [PAL_AW-1:0] pal_rd_idx,
  output logic [PAL_W-1:0]  pal_rd_data
);

  // Strobe synchronisers, bit order {ior, iow, memr, memw}
  logic [3:0] strb_meta_q, strb_sync_q;
  logic       iow_prev_q;
  // Status synchronisers, bit order {vsync_l, display_enable}
  logic [1:0] stat_meta_q, stat_sync_q;

  logic [7:0]       mode_q, mode_d;
  logic [7:0]       color_q, color_d;
  logic [7:0]       index_q, index_d;
  logic [3:0]       border_q, border_d;
  logic [4:0]       modesel_q, modesel_d;
  logic [PAL_W-1:0] pal_q [PAL_ENTRIES];

  logic              io_hit_s, wr_commit_s, status_hit_s, pal_hit_s, pal_we_s;
  logic [3:0]        ofs_s;
  logic [8:0]        idx9_s, base9_s;
  logic [PAL_AW-1:0] pal_widx_s;
  logic [7:0]        status_s;
  logic              strb_unused_s;

  assign io_hit_s     = ~bus.bus_aen & cga_hw & (bus.bus_a[14:4] == IO_BASE_ADDR[14:4]);
  assign ofs_s        = bus.bus_a[3:0];
  assign wr_commit_s  = iow_prev_q & ~strb_sync_q[2];
  assign status_hit_s = io_hit_s & (ofs_s == OFS_INDEX);
  assign crtc_cs      = io_hit_s & ~ofs_s[3];
  assign status_s     = {4'hF, stat_sync_q[1], 2'b10, ~stat_sync_q[0]};

  // Palette window test in 9 bits so PAL_BASE+PAL_ENTRIES cannot wrap
  assign idx9_s     = {1'b0, index_q};
  assign base9_s    = {1'b0, PAL_BASE};
  assign pal_hit_s  = (idx9_s >= base9_s) && (idx9_s < (base9_s + 9'(PAL_ENTRIES)));
  assign pal_widx_s = PAL_AW'(index_q - PAL_BASE);

  // The synchronised read strobe is not needed: reads are served from raw ior_l
  assign strb_unused_s = strb_sync_q[3];

  assign mode_reg    = mode_q;
  assign color_reg   = color_q;
  assign border_col  = border_q;
  assign modesel     = modesel_q;
  // Combinational read: a same-cycle write becomes visible on the next cycle
  assign pal_rd_data = pal_q[pal_rd_idx];

  // Two-flop synchronisers for the asynchronous bus strobes and CRTC status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_meta_q <= 4'b1111;
      strb_sync_q <= 4'b1111;
      iow_prev_q  <= 1'b1;
      stat_meta_q <= 2'b10;
      stat_sync_q <= 2'b10;
    end else begin
      strb_meta_q <= {bus.bus_ior_l, bus.bus_iow_l, bus.bus_memr_l, bus.bus_memw_l};
      strb_sync_q <= strb_meta_q;
      iow_prev_q  <= strb_sync_q[2];
      stat_meta_q <= {vsync_l, display_enable};
      stat_sync_q <= stat_meta_q;
    end
  end

  // Decode one committed write into register next-state values
  always_comb begin
    mode_d    = mode_q;
    color_d   = color_q;
    index_d   = index_q;
    border_d  = border_q;
    modesel_d = modesel_q;
    pal_we_s  = 1'b0;
    if (wr_commit_s && io_hit_s) begin
      case (ofs_s)
        OFS_MODE:  mode_d  = bus.bus_d;
        OFS_COLOR: color_d = bus.bus_d;
        OFS_INDEX: index_d = bus.bus_d;
        OFS_DATA: begin
          if (index_q == IDX_BORDER) begin
            border_d = bus.bus_d[3:0];
          end else if (index_q == IDX_MODESEL) begin
            modesel_d = bus.bus_d[4:0];
          end else if (pal_hit_s) begin
            pal_we_s = 1'b1;
          end else begin
            pal_we_s = 1'b0;
          end
        end
        default: pal_we_s = 1'b0;
      endcase
    end else begin
      pal_we_s = 1'b0;
    end
  end

  // Register file and palette storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 8'h29;
      color_q   <= 8'h00;
      index_q   <= 8'h00;
      border_q  <= 4'h0;
      modesel_q <= 5'h00;
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= PAL_W'(i);
      end
    end else begin
      mode_q    <= mode_d;
      color_q   <= color_d;
      index_q   <= index_d;
      border_q  <= border_d;
      modesel_q <= modesel_d;
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        if (pal_we_s && (pal_widx_s == PAL_AW'(i))) begin
          pal_q[i] <= bus.bus_d[PAL_W-1:0];
        end
      end
    end
  end

  // Read-back mux on the raw read strobe: status first, then odd CRTC offsets
  always_comb begin
    bus.bus_out = 8'h00;
    if (!bus.bus_ior_l && status_hit_s) begin
      bus.bus_out = status_s;
    end else if (!bus.bus_ior_l && crtc_cs && ofs_s[0]) begin
      bus.bus_out = crtc_dout;
    end else begin
      bus.bus_out = 8'h00;
    end
  end

  assign bus.bus_dir = (crtc_cs | status_hit_s) & ~bus.bus_ior_l;

`ifdef CGA_BUS_WAIT_EN
  logic mem_req_s;
  assign mem_req_s = mem_cs & (~strb_sync_q[1] | ~strb_sync_q[0]);

  cga_wait_gen #(
    .SLOT_START (SLOT_START),
    .SLOT_END   (SLOT_END),
    .WAIT_MAX   (WAIT_MAX)
  ) u_wait_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (mem_req_s),
    .clkdiv  (clkdiv),
    .bus_rdy (bus.bus_rdy)
  );
`else
  logic wait_unused_s;
  assign wait_unused_s = ^{mem_cs, clkdiv, strb_sync_q[1:0], SLOT_START, SLOT_END, WAIT_MAX};
  assign bus.bus_rdy   = 1'b1;
`endif

endmodule

// File: tb/tb_cga_bus_regs.sv
// Directed self-checking bench for cga_bus_regs; wait-state checks depend on CGA_BUS_WAIT_EN.
module tb_cga_bus_regs;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cga_hw = 1'b1;
  logic       mem_cs = 1'b0;
  logic [4:0] clkdiv = 5'd0;
  logic       clk_run = 1'b0;
  logic       vsync_l = 1'b1;
  logic       display_enable = 1'b0;
  logic [7:0] crtc_dout = 8'h00;
  logic       crtc_cs;
  logic [7:0] mode_reg, color_reg;
  logic [3:0] border_col;
  logic [4:0] modesel;
  logic [3:0] pal_rd_idx = 4'd0;
  logic [3:0] pal_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  cga_bus_regs_if bus_if ();

  cga_bus_regs dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus_if),
    .cga_hw         (cga_hw),
    .mem_cs         (mem_cs),
    .clkdiv         (clkdiv),
    .vsync_l        (vsync_l),
    .display_enable (display_enable),
    .crtc_dout      (crtc_dout),
    .crtc_cs        (crtc_cs),
    .mode_reg       (mode_reg),
    .color_reg      (color_reg),
    .border_col     (border_col),
    .modesel        (modesel),
    .pal_rd_idx     (pal_rd_idx),
    .pal_rd_data    (pal_rd_data)
  );

  always #5 clk = ~clk;

  // Free-running sequencer phase, changed on the falling edge; frozen at 0 when not running
  always @(negedge clk) begin
    clkdiv = clk_run ? (clkdiv + 5'd1) : 5'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [14:0] addr, input logic [7:0] data);
    bus_if.bus_a     = addr;
    bus_if.bus_d     = data;
    bus_if.bus_iow_l = 1'b0;
    tick(6);
    bus_if.bus_iow_l = 1'b1;
    tick(4);
  endtask

  task automatic io_read(input logic [14:0] addr, output logic [7:0] dout,
                         output logic dir, output logic cs);
    bus_if.bus_a     = addr;
    bus_if.bus_ior_l = 1'b0;
    #2;
    dout = bus_if.bus_out;
    dir  = bus_if.bus_dir;
    cs   = crtc_cs;
    bus_if.bus_ior_l = 1'b1;
    tick(1);
  endtask

  task automatic pal_check(input string tag, input logic [3:0] idx, input logic [3:0] exp);
    pal_rd_idx = idx;
    #1;
    check(tag, {28'd0, pal_rd_data}, {28'd0, exp});
  endtask

  initial begin
    logic [7:0] rd;
    logic       dir, cs;
    int         lows;
    bit         found;
    logic [4:0] div_at_rdy;

    bus_if.bus_a      = 15'h0000;
    bus_if.bus_d      = 8'h00;
    bus_if.bus_ior_l  = 1'b1;
    bus_if.bus_iow_l  = 1'b1;
    bus_if.bus_memr_l = 1'b1;
    bus_if.bus_memw_l = 1'b1;
    bus_if.bus_aen    = 1'b0;

    // Reset values
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_mode", {24'd0, mode_reg}, 32'h29);
    check("rst_color", {24'd0, color_reg}, 32'h00);
    check("rst_border", {28'd0, border_col}, 32'h0);
    check("rst_modesel", {27'd0, modesel}, 32'h0);
    check("rst_rdy", {31'd0, bus_if.bus_rdy}, 32'd1);
    check("rst_dir", {31'd0, bus_if.bus_dir}, 32'd0);
    check("rst_out", {24'd0, bus_if.bus_out}, 32'h00);
    pal_check("rst_pal5", 4'd5, 4'd5);

    // Long-held write strobe commits once: the data change mid-strobe must not land
    bus_if.bus_a     = 15'h3D8;
    bus_if.bus_d     = 8'h1A;
    bus_if.bus_iow_l = 1'b0;
    tick(10);
    bus_if.bus_d     = 8'h55;
    tick(10);
    bus_if.bus_iow_l = 1'b1;
    tick(4);
    check("mode_once", {24'd0, mode_reg}, 32'h1A);

    io_write(15'h3D9, 8'h3C);
    check("color_wr", {24'd0, color_reg}, 32'h3C);

    // Tandy indirect writes
    io_write(15'h3DA, 8'h13);
    io_write(15'h3DE, 8'h0C);
    pal_check("pal3", 4'd3, 4'hC);
    io_write(15'h3DA, 8'h02);
    io_write(15'h3DE, 8'h07);
    check("border", {28'd0, border_col}, 32'h7);
    io_write(15'h3DA, 8'h03);
    io_write(15'h3DE, 8'h1F);
    check("modesel", {27'd0, modesel}, 32'h1F);
    io_write(15'h3DA, 8'h05);
    io_write(15'h3DE, 8'hFF);
    check("idx5_border", {28'd0, border_col}, 32'h7);
    check("idx5_modesel", {27'd0, modesel}, 32'h1F);
    pal_check("idx5_pal5", 4'd5, 4'd5);
    // Top of the palette window and one past it
    io_write(15'h3DA, 8'h1F);
    io_write(15'h3DE, 8'h09);
    pal_check("pal15", 4'd15, 4'h9);
    io_write(15'h3DA, 8'h20);
    io_write(15'h3DE, 8'h0A);
    pal_check("idx20_pal0", 4'd0, 4'h0);
    pal_check("idx20_pal15", 4'd15, 4'h9);
    io_write(15'h3DA, 8'h0F);
    io_write(15'h3DE, 8'h0B);
    pal_check("idx0f_pal15", 4'd15, 4'h9);

    // Decode gating on writes
    bus_if.bus_aen = 1'b1;
    io_write(15'h3D8, 8'h77);
    bus_if.bus_aen = 1'b0;
    check("aen_wr", {24'd0, mode_reg}, 32'h1A);
    cga_hw = 1'b0;
    io_write(15'h3D8, 8'h66);
    cga_hw = 1'b1;
    check("hw_wr", {24'd0, mode_reg}, 32'h1A);
    io_write(15'h3B8, 8'h44);
    check("base_wr", {24'd0, mode_reg}, 32'h1A);

    // Status reads
    vsync_l = 1'b0;
    display_enable = 1'b1;
    tick(3);
    io_read(15'h3DA, rd, dir, cs);
    check("stat_f4", {24'd0, rd}, 32'hF4);
    check("stat_f4_dir", {31'd0, dir}, 32'd1);
    vsync_l = 1'b1;
    display_enable = 1'b0;
    tick(3);
    io_read(15'h3DA, rd, dir, cs);
    check("stat_fd", {24'd0, rd}, 32'hFD);
    bus_if.bus_aen = 1'b1;
    io_read(15'h3DA, rd, dir, cs);
    bus_if.bus_aen = 1'b0;
    check("aen_rd_out", {24'd0, rd}, 32'h00);
    check("aen_rd_dir", {31'd0, dir}, 32'd0);
    cga_hw = 1'b0;
    io_read(15'h3DA, rd, dir, cs);
    cga_hw = 1'b1;
    check("hw_rd_out", {24'd0, rd}, 32'h00);
    check("hw_rd_dir", {31'd0, dir}, 32'd0);
    // Index survives the status read: next data write still targets palette[15]
    io_write(15'h3DA, 8'h1F);
    io_read(15'h3DA, rd, dir, cs);
    io_write(15'h3DE, 8'h06);
    pal_check("idx_keep", 4'd15, 4'h6);

    // CRTC read-back and select
    crtc_dout = 8'hA5;
    io_read(15'h3D5, rd, dir, cs);
    check("crtc_odd_out", {24'd0, rd}, 32'hA5);
    check("crtc_odd_dir", {31'd0, dir}, 32'd1);
    check("crtc_odd_cs", {31'd0, cs}, 32'd1);
    io_read(15'h3D4, rd, dir, cs);
    check("crtc_even_out", {24'd0, rd}, 32'h00);
    check("crtc_even_dir", {31'd0, dir}, 32'd1);
    io_read(15'h3D8, rd, dir, cs);
    check("mode_rd_dir", {31'd0, dir}, 32'd0);
    check("mode_rd_cs", {31'd0, cs}, 32'd0);

`ifdef CGA_BUS_WAIT_EN
    // Wait states aligned to the sequencer slot
    clk_run = 1'b1;
    tick(3);
    mem_cs = 1'b1;
    bus_if.bus_memr_l = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!found) begin
        tick(1);
        if (bus_if.bus_rdy == 1'b0) found = 1'b1;
      end
    end
    check("ws_low", {31'd0, found}, 32'd1);
    found = 1'b0;
    div_at_rdy = 5'd0;
    for (int i = 0; i < 60; i++) begin
      if (!found) begin
        tick(1);
        if (bus_if.bus_rdy == 1'b1) begin
          found = 1'b1;
          div_at_rdy = clkdiv;
        end
      end
    end
    check("ws_release", {31'd0, found}, 32'd1);
    check("ws_slot_end", {27'd0, div_at_rdy}, 32'd20);
    tick(5);
    check("ws_done_hold", {31'd0, bus_if.bus_rdy}, 32'd1);
    bus_if.bus_memr_l = 1'b1;
    tick(5);
    bus_if.bus_memr_l = 1'b0;
    tick(4);
    check("ws_rearm", {31'd0, bus_if.bus_rdy}, 32'd0);
    bus_if.bus_memr_l = 1'b1;
    tick(4);
    check("ws_abort", {31'd0, bus_if.bus_rdy}, 32'd1);

    // Watchdog with the sequencer stalled
    clk_run = 1'b0;
    tick(4);
    bus_if.bus_memr_l = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus_if.bus_rdy == 1'b0) lows++;
    end
    check("wd_low_cycles", lows, 32'd64);
    check("wd_rdy", {31'd0, bus_if.bus_rdy}, 32'd1);
    bus_if.bus_memr_l = 1'b1;
    tick(5);
`else
    // Without wait states bus_rdy never drops
    mem_cs = 1'b1;
    bus_if.bus_memr_l = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus_if.bus_rdy == 1'b0) lows++;
    end
    check("nowait_low_cycles", lows, 32'd0);
    bus_if.bus_memr_l = 1'b1;
    tick(5);
`endif

    // Asynchronous reset in the middle of a memory cycle
    mem_cs = 1'b1;
    bus_if.bus_memw_l = 1'b0;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("arst_rdy", {31'd0, bus_if.bus_rdy}, 32'd1);
    check("arst_mode", {24'd0, mode_reg}, 32'h29);
    check("arst_border", {28'd0, border_col}, 32'h0);
    pal_check("arst_pal3", 4'd3, 4'd3);
    pal_check("arst_pal15", 4'd15, 4'd15);
    bus_if.bus_memw_l = 1'b1;
    mem_cs = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
